// File: rtl/riscv_core_dpath_dmem_resp_queue.sv
`default_nettype none
// ============================================================================
// Module   : riscv_core_dpath_dmem_resp_queue
// Purpose  : Data-memory response queue for the core datapath. Each raw
//            memory word is aligned and sign/zero-extended according to the
//            load type as it is enqueued, so the stored entry is already the
//            final writeback value. Entries are kept in a circular buffer.
//            When the queue is empty it can optionally hand the incoming
//            response straight to the consumer in the same cycle.
// Ports    : clk, reset      - clock, synchronous active-high reset
//            flush           - synchronous discard of all entries
//            enq_val/enq_rdy - response handshake (producer side)
//            enq_data        - raw memory response word (W bits)
//            enq_type        - 0 full, 1 lb, 2 lbu, 3 lh, 4 lhu, 5 lw,
//                              6 lwu, 7 same as full
//            enq_off         - byte offset of the access within the word
//            deq_val/deq_rdy - result handshake (writeback side)
//            deq_data        - extracted and extended head result
//            count           - number of stored entries
// Revision : 1.0 - initial release
// ============================================================================
module riscv_core_dpath_dmem_resp_queue #(
  parameter int W      = 32,
  parameter int DEPTH  = 2,
  parameter int BYPASS = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     enq_val,
  output logic                     enq_rdy,
  input  logic [W-1:0]             enq_data,
  input  logic [2:0]               enq_type,
  input  logic [$clog2(W/8)-1:0]   enq_off,
  output logic                     deq_val,
  input  logic                     deq_rdy,
  output logic [W-1:0]             deq_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTRW = $clog2(DEPTH);
  localparam int CNTW = PTRW + 1;
  localparam int OFFW = $clog2(W/8);

  localparam logic [2:0] c_TYPE_LB  = 3'd1;
  localparam logic [2:0] c_TYPE_LBU = 3'd2;
  localparam logic [2:0] c_TYPE_LH  = 3'd3;
  localparam logic [2:0] c_TYPE_LHU = 3'd4;
  localparam logic [2:0] c_TYPE_LW  = 3'd5;
  localparam logic [2:0] c_TYPE_LWU = 3'd6;

  localparam logic [CNTW-1:0] c_DEPTH_CNT = CNTW'(DEPTH);
  localparam logic [PTRW-1:0] c_PTR_ONE   = PTRW'(1);

  // --------------------------------------------------------------------------
  // Extraction: align the addressed bytes to bit 0, then extend.
  // --------------------------------------------------------------------------
  logic [OFFW+2:0] w_shamt;
  logic [W-1:0]    w_shifted;
  logic [W-1:0]    w_lw;
  logic [W-1:0]    w_lwu;
  logic [W-1:0]    w_ext;

  // Byte offset scaled to a bit shift; logical shift fills with zeros.
  assign w_shamt   = {enq_off, 3'b000};
  assign w_shifted = enq_data >> w_shamt;

  // On a 32-bit datapath a word load is the whole shifted value; only a
  // wider datapath needs the upper half filled.
  generate
    if (W > 32) begin : g_word_ext
      assign w_lw  = {{(W-32){w_shifted[31]}}, w_shifted[31:0]};
      assign w_lwu = {{(W-32){1'b0}},          w_shifted[31:0]};
    end else begin : g_word_pass
      assign w_lw  = w_shifted;
      assign w_lwu = w_shifted;
    end
  endgenerate

  always_comb begin
    w_ext = w_shifted;
    case (enq_type)
      c_TYPE_LB:  w_ext = {{(W-8){w_shifted[7]}},   w_shifted[7:0]};
      c_TYPE_LBU: w_ext = {{(W-8){1'b0}},           w_shifted[7:0]};
      c_TYPE_LH:  w_ext = {{(W-16){w_shifted[15]}}, w_shifted[15:0]};
      c_TYPE_LHU: w_ext = {{(W-16){1'b0}},          w_shifted[15:0]};
      c_TYPE_LW:  w_ext = w_lw;
      c_TYPE_LWU: w_ext = w_lwu;
      default:    w_ext = w_shifted;
    endcase
  end

  // --------------------------------------------------------------------------
  // Storage and control state. The data array is deliberately not reset;
  // count and pointers alone decide what is valid.
  // --------------------------------------------------------------------------
  logic [W-1:0]    mem_q [DEPTH];
  logic [PTRW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTRW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0] count_q,  count_d;

  logic w_empty;
  logic w_full;
  logic w_bypass;
  logic w_bypass_take;
  logic w_push;
  logic w_pop;

  assign w_empty = (count_q == '0);
  assign w_full  = (count_q == c_DEPTH_CNT);

  // A full queue refuses new data even if the head leaves this cycle, so
  // enq_rdy never depends on deq_rdy.
  assign enq_rdy = !w_full && !flush;

  // Pass-through candidate: nothing stored and a response is arriving.
  assign w_bypass = (BYPASS != 0) && enq_val && w_empty;

  assign deq_val  = !flush && (!w_empty || w_bypass);
  assign deq_data = w_empty ? w_ext : mem_q[rd_ptr_q];
  assign count    = count_q;

  // A bypassed response that the consumer takes is never written; if the
  // consumer stalls, the same response is stored like any other enqueue.
  assign w_bypass_take = w_bypass && deq_rdy && !flush;
  assign w_push        = enq_val && enq_rdy && !w_bypass_take;
  assign w_pop         = deq_val && deq_rdy && !w_empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (reset || flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // DEPTH is a power of two, so pointer increments wrap naturally.
      if (w_push) begin
        wr_ptr_d = wr_ptr_q + c_PTR_ONE;
      end
      if (w_pop) begin
        rd_ptr_d = rd_ptr_q + c_PTR_ONE;
      end
      count_d = count_q + CNTW'(w_push) - CNTW'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    wr_ptr_q <= wr_ptr_d;
    rd_ptr_q <= rd_ptr_d;
    count_q  <= count_d;
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      mem_q[wr_ptr_q] <= w_ext;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (count_q <= c_DEPTH_CNT)
        else $error("dmem_resp_queue: count above depth");
      assert (!(w_push && w_full))
        else $error("dmem_resp_queue: write into full queue");
    end
  end
`endif

endmodule
`default_nettype wire

// File: doc/riscv_core_dpath_dmem_resp_queue.md
RISCV_CORE_DPATH_DMEM_RESP_QUEUE -- requirements
Module: riscv_core_dpath_dmem_resp_queue

Interface
REQ-001 The block SHALL have parameter W, default 32, meaning data width in bits; legal values 32 and 64.
REQ-002 The block SHALL have parameter DEPTH, default 2, meaning storage entries; power of two, at least 2.
REQ-003 The block SHALL have parameter BYPASS, default 1, meaning 1 = empty-queue combinational pass-through enabled.
REQ-004 The block SHALL have port clk, input, 1, meaning clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset, input, 1, meaning reset, synchronous, active-high.
REQ-006 The block SHALL have port flush, input, 1, meaning synchronous discard of all entries.
REQ-007 The block SHALL have port enq_val, input, 1, meaning memory response valid.
REQ-008 The block SHALL have port enq_rdy, output, 1, meaning queue can accept a response.
REQ-009 The block SHALL have port enq_data, input, W, meaning raw memory response word.
REQ-010 The block SHALL have port enq_type, input, 3, meaning 0 full, 1 lb, 2 lbu, 3 lh, 4 lhu, 5 lw, 6 lwu, 7 treated as 0.
REQ-011 The block SHALL have port enq_off, input, log2(W/8), meaning byte offset of the access within the word.
REQ-012 The block SHALL have port deq_val, output, 1, meaning head result valid.
REQ-013 The block SHALL have port deq_rdy, input, 1, meaning consumer (writeback) accepts.
REQ-014 The block SHALL have port deq_data, output, W, meaning extracted and extended head result.
REQ-015 The block SHALL have port count, output, log2(DEPTH)+1, meaning number of stored entries.

Function
REQ-016 Enqueue SHALL occur iff enq_val && enq_rdy at a rising edge; dequeue SHALL occur iff deq_val && deq_rdy.
REQ-017 Extraction SHALL be done at enqueue: shifted = enq_data >> (8*enq_off), zeros shifted in; the extracted value is stored, not the raw word.
REQ-018 Extension SHALL be: lb/lbu use shifted[7:0] sign/zero-extended to W; lh/lhu use shifted[15:0]; lw/lwu use shifted[31:0] (for W=32 both equal shifted); full/7 pass shifted unchanged.
REQ-019 enq_rdy SHALL be (count < DEPTH) && !flush; no enqueue when full even if a dequeue occurs the same cycle.
REQ-020 deq_val SHALL be !flush && (count > 0 || (BYPASS && enq_val && count == 0)).
REQ-021 deq_data SHALL be the head entry when count > 0, else the extracted enq value when bypassing; otherwise don't-care.
REQ-022 Bypass with deq_rdy=1 SHALL leave count and pointers unchanged (entry never stored); with deq_rdy=0 the entry SHALL be stored normally.
REQ-023 Storage SHALL be a circular buffer with wr_ptr and rd_ptr of width log2(DEPTH) wrapping DEPTH-1 -> 0.
REQ-024 Simultaneous non-bypass enqueue and dequeue SHALL advance both pointers and leave count unchanged.
REQ-025 Order SHALL be strict FIFO; count SHALL never exceed DEPTH nor underflow.
REQ-026 Flush SHALL override enq/deq: next cycle count=0, wr_ptr=rd_ptr=0; the flush-cycle input is dropped.
REQ-027 Storage array contents SHALL NOT be reset; only control state is.

Reset
REQ-028 While reset=1: next-edge count=0, wr_ptr=0, rd_ptr=0; reset SHALL override flush, enq and deq.
REQ-029 After reset: deq_val=0 (unless bypass enq_val), enq_rdy=1, count=0.
REQ-030 Reset mid-operation SHALL discard all stored entries with no dequeue of stale data afterward.

Verification
REQ-031 W=32, BYPASS=1, empty, enq_val=1, enq_data=0x0000_80F0, type=lb, off=0, deq_rdy=1 -> same-cycle deq_val=1, deq_data=0xFFFF_FFF0, count stays 0.
REQ-032 W=32, deq_rdy=0, enqueue 0x1234_5678 (lhu off=2) then 0xAABB_CCDD (lb off=3) -> count=2, enq_rdy=0; on deq_rdy=1 outputs 0x0000_1234 then 0xFFFF_FFAA.
REQ-033 DEPTH=4, enqueue/dequeue 10 words continuously with count held at 2 -> FIFO order preserved across pointer wrap, count=2 throughout.
REQ-034 Full (count=DEPTH), enq_val=1, deq_rdy=1 -> enq_rdy=0, one dequeue, count=DEPTH-1 next cycle.
REQ-035 W=64, enq_data=0x8000_0001_FFFF_FFFE, type=lw off=4 -> 0xFFFF_FFFF_8000_0001; type=lwu off=0 -> 0x0000_0000_FFFF_FFFE.
REQ-036 count=2, assert flush (or reset) with enq_val=1 -> next cycle count=0, deq_val=0, the flushed entries are never output.
